ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 111 +++++++++++
 tb/tb_ram_fifo_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller around an external 8x16 dual-port RAM with a
// registered read port. The RAM holds unread words; the word sitting on the
// RAM read register is the output word, tracked by out_valid.
// Optional feature: define ALMOST_FLAGS_EN to add almost_full / almost_empty.
module ram_fifo_ctrl #(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          ram_we,
    output logic          ram_re,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_out,
    output logic [AW:0]   level
`ifdef ALMOST_FLAGS_EN
    ,
    output logic          almost_full,
    output logic          almost_empty
`endif
);

    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = '0;
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic          push;
    logic          issue;

    // Handshake decode: accept while not full, read the RAM when a word is
    // waiting and the output slot is empty or being drained this cycle.
    always_comb begin
        in_ready = (cnt_q != DEPTH_C) && !rst;
        push     = in_valid && in_ready;
        issue    = (cnt_q != CNT_ZERO) && (!out_valid_q || out_ready) && !rst;
    end

    // Next-state: pointer advance, occupancy update and output-slot tracking.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        if (push) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (issue) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        case ({push, issue})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        if (issue) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // RAM strobes and output wiring; the RAM read register is the output word.
    always_comb begin
        ram_we    = push;
        ram_waddr = wptr_q;
        ram_data  = in_data;
        ram_re    = issue;
        ram_raddr = rptr_q;
        out_valid = out_valid_q;
        out_data  = ram_out;
        level     = cnt_q + {{AW{1'b0}}, out_valid_q};
    end

`ifdef ALMOST_FLAGS_EN
    // Threshold flags derived from the occupancy counters.
    always_comb begin
        almost_full  = !rst && (cnt_q >= (DEPTH_C - CNT_ONE));
        almost_empty = rst || (level <= CNT_ONE);
    end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed bench for ram_fifo_ctrl with a behavioural RAM
// and a scoreboard queue checked by an independent output monitor.
module tb_ram_fifo_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        ram_we;
    logic        ram_re;
    logic [2:0]  ram_waddr;
    logic [2:0]  ram_raddr;
    logic [15:0] ram_data;
    logic [15:0] ram_out;
    logic [3:0]  level;
`ifdef ALMOST_FLAGS_EN
    logic        almost_full;
    logic        almost_empty;
`endif

    logic [15:0] mem [0:7];
    logic [15:0] exp_q [$];
    logic [15:0] mon_word;
    int          total;
    int          bad;

    ram_fifo_ctrl #(.DW(16), .AW(3), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_data  (ram_data),
        .ram_out   (ram_out),
        .level     (level)
`ifdef ALMOST_FLAGS_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-port RAM with a registered read port.
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_data;
        if (ram_re) ram_out <= mem[ram_raddr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (exp_q.size() == 0 && out_valid === 1'b0) begin
                done = 1'b1;
                break;
            end
            nextCycle();
        end
        checkOutput("drain_done", 32'(done), 32'd1);
    endtask

    // Output monitor: every word the consumer takes must be the oldest expected.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_word: got %0h expected none", out_data);
            end else begin
                mon_word = exp_q.pop_front();
                checkOutput("out_data", 32'(out_data), 32'(mon_word));
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        applyStimulus(1'b1, 16'hAAAA, 1'b1);

        // Reset state: strobes gated even with in_valid high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
        checkOutput("rst_ram_re", 32'(ram_re), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
`ifdef ALMOST_FLAGS_EN
        checkOutput("rst_almost_empty", 32'(almost_empty), 32'd1);
        checkOutput("rst_almost_full", 32'(almost_full), 32'd0);
`endif
        applyStimulus(1'b0, 16'h0000, 1'b0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Single word: write cycle 1, read cycle 2, output cycle 3.
        nextCycle();
        applyStimulus(1'b1, 16'h1111, 1'b1);
        exp_q.push_back(16'h1111);
        @(negedge clk);
        checkOutput("c1_ram_we", 32'(ram_we), 32'd1);
        checkOutput("c1_ram_waddr", 32'(ram_waddr), 32'd0);
        checkOutput("c1_ram_data", 32'(ram_data), 32'h1111);
        checkOutput("c1_ram_re", 32'(ram_re), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        checkOutput("c2_ram_re", 32'(ram_re), 32'd1);
        checkOutput("c2_ram_raddr", 32'(ram_raddr), 32'd0);
        checkOutput("c2_level", 32'(level), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("c3_out_valid", 32'(out_valid), 32'd1);
        checkOutput("c3_level", 32'(level), 32'd1);
`ifdef ALMOST_FLAGS_EN
        checkOutput("c3_almost_empty", 32'(almost_empty), 32'd1);
`endif
        nextCycle();
        @(negedge clk);
        checkOutput("c4_level", 32'(level), 32'd0);

        // Fill with the consumer stalled: nine words fit, the tenth is refused.
        nextCycle();
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b0);
            @(negedge clk);
            checkOutput("fill_in_ready", 32'(in_ready), (i <= 9) ? 32'd1 : 32'd0);
`ifdef ALMOST_FLAGS_EN
            if (i == 9) checkOutput("fill_almost_full", 32'(almost_full), 32'd1);
`endif
            if (i <= 9) exp_q.push_back(16'(i));
            nextCycle();
        end
        applyStimulus(1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        checkOutput("full_level", 32'(level), 32'd9);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("full_out_valid", 32'(out_valid), 32'd1);
        checkOutput("full_out_data", 32'(out_data), 32'h0001);
`ifdef ALMOST_FLAGS_EN
        checkOutput("full_almost_empty", 32'(almost_empty), 32'd0);
`endif

        // Drain at one word per cycle; nine edges empty the FIFO.
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        repeat (9) nextCycle();
        @(negedge clk);
        checkOutput("drain9_level", 32'(level), 32'd0);
        checkOutput("drain9_queue", 32'(exp_q.size()), 32'd0);

        // Build level 4, then push and pop together for twenty cycles.
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'h0200 + 16'(i), 1'b0);
            exp_q.push_back(16'h0200 + 16'(i));
            nextCycle();
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 16'h0300 + 16'(i), 1'b1);
            exp_q.push_back(16'h0300 + 16'(i));
            @(negedge clk);
            checkOutput("steady_level", 32'(level), 32'd4);
            nextCycle();
        end
        applyStimulus(1'b0, 16'h0000, 1'b1);
        waitDrain(40);

        // Level 5 with a word pending, then asynchronous reset between edges.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h0400 + 16'(i), 1'b0);
            nextCycle();
        end
        applyStimulus(1'b1, 16'h0500, 1'b0);
        @(negedge clk);
        checkOutput("pre_rst_level", 32'(level), 32'd5);
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_level", 32'(level), 32'd0);
        checkOutput("arst_ram_we", 32'(ram_we), 32'd0);
        checkOutput("arst_ram_re", 32'(ram_re), 32'd0);
        exp_q.delete();
        nextCycle();
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        checkOutput("rel_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rel_out_valid", 32'(out_valid), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 16'hBEEF, 1'b1);
        exp_q.push_back(16'hBEEF);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        waitDrain(20);
        checkOutput("final_level", 32'(level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
